// File: rtl/cnt_shift.sv
// cnt_shift: tick divider driving a loadable up/down wrap/saturate counter
// with a registered four-mode barrel shifter on the count.
module cnt_shift #(
    parameter int WIDTH = 16,
    parameter int CLK_DIV = 100_000_000,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             cnt_shift_port_clk,
    input  logic             cnt_shift_port_rst_n,
    input  logic             cnt_shift_clk_rst,
    input  logic             cnt_shift_load,
    input  logic [WIDTH-1:0] cnt_shift_input,
    input  logic             cnt_shift_en,
    input  logic             cnt_shift_up,
    input  logic             cnt_shift_wrap,
    input  logic [SHW-1:0]   cnt_shift_shamt,
    input  logic [1:0]       cnt_shift_mode,
    output logic [WIDTH-1:0] cnt_shift_port_count,
    output logic [WIDTH-1:0] cnt_shift_port_shifted,
    output logic             cnt_shift_port_tick,
    output logic             cnt_shift_port_at_limit
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] ONES = '1;

    logic [DW-1:0] div;
    logic div_wrap;
    logic tick;
    logic [WIDTH-1:0] count, count_nx, shifted, shift_res, asr, ror;
    logic [SHW-1:0] rot;
    logic at_max, at_min;

    assign div_wrap = div == DIV_MAX;

    always_ff @(posedge cnt_shift_port_clk)
        if (!cnt_shift_port_rst_n || cnt_shift_clk_rst) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            div  <= div_wrap ? '0 : div + 1'b1;
            tick <= div_wrap;
        end

    assign at_max = count == ONES;
    assign at_min = count == '0;

    // load beats counting; saturate only matters when already at the limit
    assign count_nx = cnt_shift_load ? cnt_shift_input
                    : !(tick && cnt_shift_en) ? count
                    : cnt_shift_up ? ((at_max && !cnt_shift_wrap) ? count : count + 1'b1)
                    : ((at_min && !cnt_shift_wrap) ? count : count - 1'b1);

    assign rot = SHW'(cnt_shift_shamt % WIDTH);
    assign asr = $signed(count) >>> cnt_shift_shamt;
    assign ror = WIDTH'({count, count} >> rot);

    assign shift_res = cnt_shift_mode == 2'b00 ? count << cnt_shift_shamt
                     : cnt_shift_mode == 2'b01 ? count >> cnt_shift_shamt
                     : cnt_shift_mode == 2'b10 ? asr
                     : ror;

    always_ff @(posedge cnt_shift_port_clk)
        if (!cnt_shift_port_rst_n) begin
            count   <= '0;
            shifted <= '0;
        end else begin
            count   <= count_nx;
            shifted <= shift_res;
        end

    assign cnt_shift_port_count    = count;
    assign cnt_shift_port_shifted  = shifted;
    assign cnt_shift_port_tick     = tick;
    assign cnt_shift_port_at_limit = cnt_shift_up ? at_max : at_min;
endmodule

// File: tb/tb_cnt_shift.sv
// tb_cnt_shift: randomized + directed scoreboard bench for cnt_shift against
// an arithmetic reference model.
module tb_cnt_shift;
    localparam int W = 16;
    localparam int DIV = 2;
    localparam int MODV = 1 << W;
    localparam int MAXV = MODV - 1;
    localparam int HALF = MODV / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, clk_rst = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0, wrap = 1'b0;
    logic [W-1:0] din = '0;
    logic [3:0] shamt = '0;
    logic [1:0] mode = '0;
    logic [W-1:0] count, shifted;
    logic tick, at_limit;

    cnt_shift #(.WIDTH(W), .CLK_DIV(DIV)) dut (
        .cnt_shift_port_clk(clk),
        .cnt_shift_port_rst_n(rst_n),
        .cnt_shift_clk_rst(clk_rst),
        .cnt_shift_load(load),
        .cnt_shift_input(din),
        .cnt_shift_en(en),
        .cnt_shift_up(up),
        .cnt_shift_wrap(wrap),
        .cnt_shift_shamt(shamt),
        .cnt_shift_mode(mode),
        .cnt_shift_port_count(count),
        .cnt_shift_port_shifted(shifted),
        .cnt_shift_port_tick(tick),
        .cnt_shift_port_at_limit(at_limit)
    );

    typedef struct {
        int cnt;
        int sh;
        bit tk;
        bit lim;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail = 0;
    int m_cnt = 0, m_sh = 0, m_age = 0;
    bit m_tick = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endfunction

    // shift result from plain arithmetic on the unsigned value
    function automatic int ref_shift(int c, int sa, int md);
        int p, r;
        if (sa >= W && md != 3) return (md == 2 && c >= HALF) ? MAXV : 0;
        p = 1 << sa;
        case (md)
            0: return (c * p) % MODV;
            1: return c / p;
            2: return c / p + ((c >= HALF) ? (MODV - MODV / p) : 0);
            default: begin
                r = sa % W;
                return c / (1 << r) + (c % (1 << r)) * (1 << (W - r));
            end
        endcase
    endfunction

    // one clock: model the edge from the inputs now applied, then step past it
    task automatic cyc(int n);
        exp_t e;
        int nc, ns;
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) begin
                m_cnt = 0; m_sh = 0; m_tick = 1'b0; m_age = 0;
            end else begin
                ns = ref_shift(m_cnt, int'(shamt), int'(mode));
                if (load) nc = int'(din);
                else if (m_tick && en && up) nc = (m_cnt == MAXV) ? (wrap ? 0 : MAXV) : m_cnt + 1;
                else if (m_tick && en) nc = (m_cnt == 0) ? (wrap ? MAXV : 0) : m_cnt - 1;
                else nc = m_cnt;
                m_age = clk_rst ? 0 : m_age + 1;
                m_tick = m_age > 0 && m_age % DIV == 0;
                m_cnt = nc;
                m_sh = ns;
            end
            e.cnt = m_cnt;
            e.sh = m_sh;
            e.tk = m_tick;
            e.lim = up ? (m_cnt == MAXV) : (m_cnt == 0);
            q.push_back(e);
            @(posedge clk);
            #2;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_count", 32'(count), 32'(e.cnt));
                chk("sb_shifted", 32'(shifted), 32'(e.sh));
                chk("sb_tick", 32'(tick), 32'(e.tk));
                chk("sb_at_limit", 32'(at_limit), 32'(e.lim));
            end
        end
    end

    task automatic shift_case(string nm, logic [W-1:0] v, logic [1:0] md, logic [3:0] sa, logic [W-1:0] req);
        en = 1'b0; load = 1'b1; din = v; mode = md; shamt = sa;
        cyc(1);
        load = 1'b0;
        cyc(1);
        chk(nm, 32'(shifted), 32'(req));
    endtask

    initial begin : stim
        cyc(2);
        chk("rst_count", 32'(count), 0);
        chk("rst_shifted", 32'(shifted), 0);
        chk("rst_tick", 32'(tick), 0);
        rst_n = 1'b1;
        cyc(1);
        chk("tick_edge1", 32'(tick), 0);
        cyc(1);
        chk("tick_edge2", 32'(tick), 1);
        cyc(1);
        chk("tick_edge3", 32'(tick), 0);

        load = 1'b1; din = 16'h0008; mode = 2'b00; shamt = 4'd3;
        cyc(1);
        chk("load_count", 32'(count), 32'h0008);
        load = 1'b0;
        cyc(1);
        chk("load_lsl3", 32'(shifted), 32'h0040);
        load = 1'b1; en = 1'b1; up = 1'b1;
        cyc(4);
        chk("load_hold", 32'(count), 32'h0008);

        din = 16'hFFFE; wrap = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(4);
        chk("up_wrap", 32'(count), 32'h0000);
        chk("up_wrap_lim", 32'(at_limit), 0);
        load = 1'b1; wrap = 1'b0;
        cyc(1);
        load = 1'b0;
        cyc(8);
        chk("up_sat", 32'(count), 32'hFFFF);
        chk("up_sat_lim", 32'(at_limit), 1);

        load = 1'b1; din = 16'h0001; up = 1'b0;
        cyc(1);
        load = 1'b0;
        cyc(8);
        chk("dn_sat", 32'(count), 32'h0000);
        chk("dn_sat_lim", 32'(at_limit), 1);
        wrap = 1'b1;
        cyc(2);
        chk("dn_wrap", 32'(count), 32'hFFFF);

        shift_case("asr_8000_4", 16'h8000, 2'b10, 4'd4, 16'hF800);
        shift_case("ror_0001_1", 16'h0001, 2'b11, 4'd1, 16'h8000);
        shift_case("ror_1234_0", 16'h1234, 2'b11, 4'd0, 16'h1234);
        shift_case("lsr_1234_15", 16'h1234, 2'b01, 4'd15, 16'h0000);

        clk_rst = 1'b1;
        cyc(1);
        clk_rst = 1'b0;
        chk("clkrst_tick0", 32'(tick), 0);
        cyc(1);
        chk("clkrst_tick1", 32'(tick), 0);
        cyc(1);
        chk("clkrst_tick2", 32'(tick), 1);
        chk("clkrst_count", 32'(count), 32'h1234);

        load = 1'b1; din = 16'h00A5;
        cyc(1);
        chk("pre_rst_count", 32'(count), 32'h00A5);
        load = 1'b0; rst_n = 1'b0;
        cyc(1);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_shifted", 32'(shifted), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(63) != 0);
            clk_rst = ($urandom_range(15) == 0);
            load = ($urandom_range(7) == 0);
            din = W'($urandom);
            en = ($urandom_range(7) != 0);
            up = 1'($urandom);
            wrap = 1'($urandom);
            shamt = 4'($urandom);
            mode = 2'($urandom);
            cyc(1);
        end

        #2;
        chk("queue_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
